surf_event_merger: RTL and testbench



---
 rtl/surf_event_merger.sv | 199 +++++++++++++++++++
 tb/tb_surf_event_merger.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/surf_event_merger.sv
// surf_event_merger: packet-granular round-robin merger of the per-SURF byte
// streams into one header-tagged event stream, with a per-packet length watchdog.
module surf_event_merger #(
  parameter int unsigned NSURF   = 7,
  parameter logic [3:0]  HDR_TAG = 4'hA,
  parameter int unsigned MAX_LEN = 4096
) (
  input  logic             sysclk_i,
  input  logic             rst_i,
  input  logic [NSURF-1:0] enable_i,
  input  logic [7:0]       s_s0_tdata,
  input  logic             s_s0_tvalid,
  output logic             s_s0_tready,
  input  logic             s_s0_tlast,
  input  logic [7:0]       s_s1_tdata,
  input  logic             s_s1_tvalid,
  output logic             s_s1_tready,
  input  logic             s_s1_tlast,
  input  logic [7:0]       s_s2_tdata,
  input  logic             s_s2_tvalid,
  output logic             s_s2_tready,
  input  logic             s_s2_tlast,
  input  logic [7:0]       s_s3_tdata,
  input  logic             s_s3_tvalid,
  output logic             s_s3_tready,
  input  logic             s_s3_tlast,
  input  logic [7:0]       s_s4_tdata,
  input  logic             s_s4_tvalid,
  output logic             s_s4_tready,
  input  logic             s_s4_tlast,
  input  logic [7:0]       s_s5_tdata,
  input  logic             s_s5_tvalid,
  output logic             s_s5_tready,
  input  logic             s_s5_tlast,
  input  logic [7:0]       s_s6_tdata,
  input  logic             s_s6_tvalid,
  output logic             s_s6_tready,
  input  logic             s_s6_tlast,
  output logic [7:0]       m_ev_tdata,
  output logic             m_ev_tvalid,
  input  logic             m_ev_tready,
  output logic             m_ev_tlast,
  output logic             busy_o,
  output logic [2:0]       current_o,
  output logic             trunc_o,
  output logic [15:0]      pkt_count_o,
  output logic [15:0]      err_count_o
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, FLUSH} state_e;

  localparam logic [15:0] LAST_BEAT = 16'(MAX_LEN - 1);
  localparam logic [2:0]  PTR_RST   = 3'(NSURF - 1);
  localparam logic [3:0]  NSURF_W   = 4'(NSURF);

  state_e      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [15:0] beatCnt_q, beatCnt_d;
  logic [15:0] pktCnt_q, pktCnt_d;
  logic [15:0] errCnt_q, errCnt_d;
  logic        trunc_q, trunc_d;

  logic [7:0] srcData [8];
  logic [7:0] srcValid;
  logic [7:0] srcLast;
  logic [7:0] srcReady;
  logic [7:0] req;
  logic [3:0] candSum;
  logic [2:0] hitIdx;
  logic       hit;
  logic       selValid;
  logic       selLast;
  logic [7:0] selData;

  // Slot 7 is tied permanently idle so every 3-bit index is legal.
  assign srcData[0] = s_s0_tdata;
  assign srcData[1] = s_s1_tdata;
  assign srcData[2] = s_s2_tdata;
  assign srcData[3] = s_s3_tdata;
  assign srcData[4] = s_s4_tdata;
  assign srcData[5] = s_s5_tdata;
  assign srcData[6] = s_s6_tdata;
  assign srcData[7] = 8'h00;
  assign srcValid = {1'b0, s_s6_tvalid, s_s5_tvalid, s_s4_tvalid,
                     s_s3_tvalid, s_s2_tvalid, s_s1_tvalid, s_s0_tvalid};
  assign srcLast  = {1'b0, s_s6_tlast, s_s5_tlast, s_s4_tlast,
                     s_s3_tlast, s_s2_tlast, s_s1_tlast, s_s0_tlast};

  assign s_s0_tready = srcReady[0];
  assign s_s1_tready = srcReady[1];
  assign s_s2_tready = srcReady[2];
  assign s_s3_tready = srcReady[3];
  assign s_s4_tready = srcReady[4];
  assign s_s5_tready = srcReady[5];
  assign s_s6_tready = srcReady[6];

  // Walk the ring from farthest to nearest so the nearest requester after ptr wins.
  always_comb begin
    req = '0;
    req[NSURF-1:0] = enable_i & srcValid[NSURF-1:0];
    hit = 1'b0;
    hitIdx = '0;
    candSum = '0;
    for (int k = NSURF; k >= 1; k--) begin
      candSum = {1'b0, ptr_q} + 4'(k);
      if (candSum >= NSURF_W) candSum = candSum - NSURF_W;
      if (req[candSum[2:0]]) begin
        hit = 1'b1;
        hitIdx = candSum[2:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    beatCnt_d = beatCnt_q;
    pktCnt_d = pktCnt_q;
    errCnt_d = errCnt_q;
    trunc_d = 1'b0;
    srcReady = '0;
    m_ev_tvalid = 1'b0;
    m_ev_tdata = 8'h00;
    m_ev_tlast = 1'b0;
    selValid = srcValid[sel_q];
    selLast = srcLast[sel_q];
    selData = srcData[sel_q];
    case (state_q)
      IDLE: begin
        if (hit) begin
          sel_d = hitIdx;
          beatCnt_d = '0;
          state_d = HDR;
        end
      end
      HDR: begin
        m_ev_tvalid = 1'b1;
        m_ev_tdata = {HDR_TAG, 1'b0, sel_q};
        if (m_ev_tready) state_d = DATA;
      end
      DATA: begin
        m_ev_tvalid = selValid;
        m_ev_tdata = selData;
        m_ev_tlast = selLast | (beatCnt_q == LAST_BEAT);
        srcReady[sel_q] = m_ev_tready;
        if (selValid && m_ev_tready) begin
          beatCnt_d = beatCnt_q + 16'd1;
          if (selLast) begin
            state_d = IDLE;
            ptr_d = sel_q;
            if (pktCnt_q != 16'hFFFF) pktCnt_d = pktCnt_q + 16'd1;
          end else if (beatCnt_q == LAST_BEAT) begin
            trunc_d = 1'b1;
            if (errCnt_q != 16'hFFFF) errCnt_d = errCnt_q + 16'd1;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        // Drain the remainder of a runaway packet without forwarding it.
        srcReady[sel_q] = 1'b1;
        if (selValid && selLast) begin
          state_d = IDLE;
          ptr_d = sel_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q <= '0;
      ptr_q <= PTR_RST;
      beatCnt_q <= '0;
      pktCnt_q <= '0;
      errCnt_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      beatCnt_q <= beatCnt_d;
      pktCnt_q <= pktCnt_d;
      errCnt_q <= errCnt_d;
      trunc_q <= trunc_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign current_o = sel_q;
  assign trunc_o = trunc_q;
  assign pkt_count_o = pktCnt_q;
  assign err_count_o = errCnt_q;

endmodule

// File: tb/tb_surf_event_merger.sv
// Testbench for surf_event_merger: per-source packet queues feed the DUT while a
// monitor checks the merged stream against per-source expected-byte queues.
module tb_surf_event_merger;

  localparam int NS = 7;
  localparam int MAXL = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [NS-1:0] enable;
  logic [7:0]    sData [NS];
  logic [NS-1:0] sValid, sLast, sReady;
  logic [7:0]    mData;
  logic          mValid, mReady, mLast, busy, trunc;
  logic [2:0]    current;
  logic [15:0]   pktCount, errCount;

  surf_event_merger #(.NSURF(NS), .HDR_TAG(4'hA), .MAX_LEN(MAXL)) dut (
    .sysclk_i(clock), .rst_i(reset), .enable_i(enable),
    .s_s0_tdata(sData[0]), .s_s0_tvalid(sValid[0]), .s_s0_tready(sReady[0]), .s_s0_tlast(sLast[0]),
    .s_s1_tdata(sData[1]), .s_s1_tvalid(sValid[1]), .s_s1_tready(sReady[1]), .s_s1_tlast(sLast[1]),
    .s_s2_tdata(sData[2]), .s_s2_tvalid(sValid[2]), .s_s2_tready(sReady[2]), .s_s2_tlast(sLast[2]),
    .s_s3_tdata(sData[3]), .s_s3_tvalid(sValid[3]), .s_s3_tready(sReady[3]), .s_s3_tlast(sLast[3]),
    .s_s4_tdata(sData[4]), .s_s4_tvalid(sValid[4]), .s_s4_tready(sReady[4]), .s_s4_tlast(sLast[4]),
    .s_s5_tdata(sData[5]), .s_s5_tvalid(sValid[5]), .s_s5_tready(sReady[5]), .s_s5_tlast(sLast[5]),
    .s_s6_tdata(sData[6]), .s_s6_tvalid(sValid[6]), .s_s6_tready(sReady[6]), .s_s6_tlast(sLast[6]),
    .m_ev_tdata(mData), .m_ev_tvalid(mValid), .m_ev_tready(mReady), .m_ev_tlast(mLast),
    .busy_o(busy), .current_o(current), .trunc_o(trunc),
    .pkt_count_o(pktCount), .err_count_o(errCount)
  );

  // Each entry is {tlast, tdata}.
  logic [8:0] srcq [NS][$];
  logic [8:0] expq [NS][$];
  int hdrLog[$];
  int nChecks = 0;
  int nPass = 0;
  int expPkt = 0;
  int expErr = 0;
  int truncSeen = 0;
  int readyMode = 0;
  bit gapEn = 1'b0;
  logic [NS-1:0] allowMask = '0;
  bit inPkt = 1'b0;
  int curSrc = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Queue a packet on a source; the expected merged bytes follow the truncation rule.
  task automatic applyStimulus(input int src, input int len, input logic [7:0] first,
                               input logic [7:0] step, input bit expectOut);
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      b = (step == 8'h00) ? 8'($urandom) : first + 8'(k) * step;
      srcq[src].push_back({k == len - 1, b});
      if (expectOut && k < MAXL) expq[src].push_back({(k == len - 1) || (k == MAXL - 1), b});
    end
    if (expectOut) begin
      if (len > MAXL) expErr++;
      else expPkt++;
    end
  endtask

  function automatic bit drained();
    if (inPkt) return 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (expq[i].size() != 0) return 1'b0;
      if (enable[i] && srcq[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic waitDrain(input int budget);
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clock);
      n++;
      if (!busy && !mValid && drained()) quiet++;
      else quiet = 0;
    end
    checkOutput("drainTimeout", 32'(quiet >= 3), 32'd1);
  endtask

  task automatic waitHeader(input int src, input int budget);
    int n = 0;
    while (!(inPkt && curSrc == src) && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput("headerTimeout", 32'(inPkt && curSrc == src), 32'd1);
  endtask

  // Source drivers and downstream ready; handshakes are sampled at the negedge.
  initial begin : driver
    bit fired [NS];
    sValid = '0;
    sLast = '0;
    mReady = 1'b1;
    for (int i = 0; i < NS; i++) sData[i] = 8'h00;
    forever begin
      @(negedge clock);
      for (int i = 0; i < NS; i++) fired[i] = sValid[i] && sReady[i];
      @(posedge clock);
      #1;
      case (readyMode)
        0: mReady = 1'b1;
        1: mReady = ~mReady;
        default: mReady = 1'($urandom_range(0, 1));
      endcase
      for (int i = 0; i < NS; i++) begin
        if (reset) begin
          sValid[i] = 1'b0;
        end else begin
          if (fired[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
          if (!(sValid[i] && !fired[i])) begin
            if (srcq[i].size() > 0 && (!gapEn || $urandom_range(0, 3) != 0)) begin
              sValid[i] = 1'b1;
              sData[i] = srcq[i][0][7:0];
              sLast[i] = srcq[i][0][8];
            end else begin
              sValid[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Monitor: header decode, per-source data scoreboard, stall stability.
  initial begin : monitor
    bit prevStall;
    bit okSrc;
    logic [8:0] prevBeat;
    logic [8:0] e;
    prevStall = 1'b0;
    prevBeat = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        inPkt = 1'b0;
        prevStall = 1'b0;
        truncSeen = 0;
      end else begin
        if (trunc) truncSeen++;
        if (prevStall) checkOutput("holdWhileStalled", {23'd0, mValid, mLast, mData}, {23'd0, 1'b1, prevBeat});
        if (mValid && mReady) begin
          if (!inPkt) begin
            checkOutput("headerTag", {26'd0, mLast, mData[7:3]}, {26'd0, 1'b0, 4'hA, 1'b0});
            curSrc = int'(mData[2:0]);
            okSrc = (curSrc < NS) ? allowMask[curSrc] : 1'b0;
            checkOutput("headerSource", 32'(okSrc), 32'd1);
            if (okSrc) begin
              inPkt = 1'b1;
              hdrLog.push_back(curSrc);
            end
          end else begin
            if (expq[curSrc].size() == 0) begin
              nChecks++;
              $display("[TB] FAIL unexpectedBeat: got 0x%0h from source %0d, expected no beat",
                       {mLast, mData}, curSrc);
            end else begin
              e = expq[curSrc].pop_front();
              checkOutput("dataBeat", {23'd0, mLast, mData}, {23'd0, e});
            end
            if (mLast) inPkt = 1'b0;
          end
        end
        prevStall = mValid && !mReady;
        prevBeat = {mLast, mData};
      end
    end
  end

  initial begin : main
    int rem [NS];
    int expOrder[$];
    int p;
    int c;
    reset = 1'b1;
    enable = '0;
    repeat (3) @(posedge clock);
    #2;
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetOutputs", {22'd0, mValid, mLast, mData}, 32'd0);
    checkOutput("resetReady", 32'(sReady), 32'd0);
    checkOutput("resetCounters", {pktCount, errCount}, 32'd0);
    checkOutput("resetCurrentTrunc", {28'd0, current, trunc}, 32'd0);
    reset = 1'b0;

    $display("[TB] single source");
    enable = 7'h01;
    allowMask = 7'h01;
    applyStimulus(0, 4, 8'hAA, 8'h11, 1'b1);
    waitDrain(200);
    checkOutput("singleHeader", (hdrLog.size() == 1) ? hdrLog[0] : -1, 32'd0);
    checkOutput("singlePktCount", {16'd0, pktCount}, 32'(expPkt));
    checkOutput("singleCurrent", {29'd0, current}, 32'd0);

    $display("[TB] round robin");
    hdrLog.delete();
    enable = 7'b1001010;
    allowMask = 7'b1001010;
    for (int i = 0; i < NS; i++) rem[i] = 0;
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1, 2, 8'h00, 8'h00, 1'b1);
      applyStimulus(3, 2, 8'h00, 8'h00, 1'b1);
      applyStimulus(6, 2, 8'h00, 8'h00, 1'b1);
      rem[1]++; rem[3]++; rem[6]++;
    end
    waitDrain(400);
    p = 0;  // s0 was the last source served
    for (int k = 0; k < 9; k++) begin
      for (int d = 1; d <= NS; d++) begin
        c = (p + d) % NS;
        if (rem[c] > 0) begin
          expOrder.push_back(c);
          rem[c]--;
          p = c;
          break;
        end
      end
    end
    checkOutput("rrCount", hdrLog.size(), expOrder.size());
    for (int k = 0; k < expOrder.size() && k < hdrLog.size(); k++)
      checkOutput("rrOrder", hdrLog[k], expOrder[k]);

    $display("[TB] backpressure");
    enable = 7'h20;
    allowMask = 7'h20;
    readyMode = 1;
    applyStimulus(5, 16, 8'h10, 8'h01, 1'b1);
    waitDrain(400);
    readyMode = 0;
    checkOutput("bpPktCount", {16'd0, pktCount}, 32'(expPkt));

    $display("[TB] truncation and exact length");
    enable = 7'h04;
    allowMask = 7'h04;
    applyStimulus(2, 12, 8'h40, 8'h01, 1'b1);
    waitDrain(400);
    checkOutput("truncErrCount", {16'd0, errCount}, 32'(expErr));
    checkOutput("truncPulses", truncSeen, expErr);
    applyStimulus(2, MAXL, 8'h60, 8'h01, 1'b1);
    applyStimulus(2, 3, 8'h70, 8'h01, 1'b1);
    waitDrain(400);
    checkOutput("exactPktCount", {16'd0, pktCount}, 32'(expPkt));
    checkOutput("exactErrCount", {16'd0, errCount}, 32'(expErr));
    checkOutput("exactPulses", truncSeen, expErr);

    $display("[TB] randomized traffic");
    enable = 7'h7F;
    allowMask = 7'h7F;
    readyMode = 2;
    gapEn = 1'b1;
    for (int n = 0; n < 40; n++) begin
      applyStimulus($urandom_range(0, NS - 1), $urandom_range(1, 12), 8'h00, 8'h00, 1'b1);
      repeat ($urandom_range(0, 6)) @(posedge clock);
    end
    waitDrain(20000);
    readyMode = 0;
    gapEn = 1'b0;
    checkOutput("randPktCount", {16'd0, pktCount}, 32'(expPkt));
    checkOutput("randErrCount", {16'd0, errCount}, 32'(expErr));
    checkOutput("randPulses", truncSeen, expErr);

    $display("[TB] disable mid-packet");
    applyStimulus(4, MAXL, 8'h80, 8'h01, 1'b1);
    waitHeader(4, 200);
    enable[4] = 1'b0;
    allowMask[4] = 1'b0;
    applyStimulus(4, 3, 8'h90, 8'h01, 1'b0);
    applyStimulus(0, 3, 8'hA0, 8'h01, 1'b1);
    waitDrain(400);
    repeat (10) @(negedge clock);
    checkOutput("disabledLeftQueued", srcq[4].size(), 32'd3);
    checkOutput("disablePktCount", {16'd0, pktCount}, 32'(expPkt));

    $display("[TB] reset mid-packet");
    enable = 7'h01;
    allowMask = 7'h01;
    applyStimulus(0, 6, 8'hC0, 8'h01, 1'b1);
    waitHeader(0, 200);
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    checkOutput("midResetReady", 32'(sReady), 32'd0);
    checkOutput("midResetValid", 32'(mValid), 32'd0);
    checkOutput("midResetCounters", {pktCount, errCount}, 32'd0);
    for (int i = 0; i < NS; i++) begin
      srcq[i].delete();
      expq[i].delete();
    end
    expPkt = 0;
    expErr = 0;
    hdrLog.delete();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    enable = 7'h02;
    allowMask = 7'h02;
    applyStimulus(1, 3, 8'hD0, 8'h01, 1'b1);
    waitDrain(400);
    checkOutput("postResetPktCount", {16'd0, pktCount}, 32'(expPkt));
    checkOutput("postResetErrCount", {16'd0, errCount}, 32'd0);
    checkOutput("postResetHeader", (hdrLog.size() == 1) ? hdrLog[0] : -1, 32'd1);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
